ex_mem_skid: RTL and testbench

EX_MEM_SKID -- requirements
Module: ex_mem_skid

---
 rtl/ex_mem_skid.sv | 120 ++++++++++++
 tb/tb_ex_mem_skid.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/ex_mem_skid.sv
// rtl/ex_mem_skid.sv - EX/MEM pipeline register with a two-entry skid buffer
module ex_mem_skid #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              flush,
  input  logic              mem_read_i,
  input  logic              mem_write_i,
  input  logic              mem_to_reg_i,
  input  logic              reg_write_i,
  input  logic              jump_i,
  input  logic              branch_i,
  input  logic              zero_i,
  input  logic              reg_dst_i,
  input  logic [XLEN-1:0]   alu_result_i,
  input  logic [XLEN-1:0]   rt_data_i,
  input  logic [XLEN-1:0]   imm_i,
  input  logic [REG_AW-1:0] rt_i,
  input  logic [REG_AW-1:0] rd_i,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              mem_read_o,
  output logic              mem_write_o,
  output logic              mem_to_reg_o,
  output logic              reg_write_o,
  output logic              jump_o,
  output logic              branch_o,
  output logic              zero_o,
  output logic [XLEN-1:0]   alu_result_o,
  output logic [XLEN-1:0]   rt_data_o,
  output logic [XLEN-1:0]   imm_o,
  output logic [REG_AW-1:0] wb_reg_o
);

  // Entry layout: 7 control bits, three XLEN payloads, resolved write-back register
  localparam int W = 7 + 3 * XLEN + REG_AW;

  // Valid-bit pairs {main, skid}; skid-only is unreachable
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b10,
    FULL  = 2'b11
  } state_t;

  state_t         state_q;
  logic [W-1:0]   main_q;
  logic [W-1:0]   skid_q;
  logic [W-1:0]   in_entry;
  logic           accept;
  logic           pop;
  logic           m_mem_read;
  logic           m_mem_write;
  logic           m_reg_write;
  logic           m_jump;
  logic           m_branch;

  // Destination register is chosen here so reg_dst never has to be stored
  assign in_entry = {mem_read_i, mem_write_i, mem_to_reg_i, reg_write_i,
                     jump_i, branch_i, zero_i,
                     alu_result_i, rt_data_i, imm_i,
                     (reg_dst_i ? rd_i : rt_i)};

  // Ready comes only from registered state, never from out_ready
  assign in_ready  = (state_q != FULL);
  assign out_valid = (state_q != EMPTY);
  assign accept    = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // Occupancy and entry storage; flush drops everything but leaves payload held
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else if (flush) begin
      state_q <= EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            main_q  <= in_entry;
            state_q <= ONE;
          end
        end
        ONE: begin
          if (accept && pop) begin
            main_q <= in_entry;
          end else if (accept) begin
            skid_q  <= in_entry;
            state_q <= FULL;
          end else if (pop) begin
            state_q <= EMPTY;
          end
        end
        FULL: begin
          if (pop) begin
            main_q  <= skid_q;
            state_q <= ONE;
          end
        end
        default: state_q <= EMPTY;
      endcase
    end
  end

  assign {m_mem_read, m_mem_write, mem_to_reg_o, m_reg_write, m_jump, m_branch,
          zero_o, alu_result_o, rt_data_o, imm_o, wb_reg_o} = main_q;

  // Bubbles must not carry side effects, so these are gated by out_valid
  assign mem_read_o  = m_mem_read  & out_valid;
  assign mem_write_o = m_mem_write & out_valid;
  assign reg_write_o = m_reg_write & out_valid;
  assign jump_o      = m_jump      & out_valid;
  assign branch_o    = m_branch    & out_valid;

endmodule

// File: tb/tb_ex_mem_skid.sv
// tb/tb_ex_mem_skid.sv - scoreboard bench for ex_mem_skid
module tb_ex_mem_skid;

  localparam int XLEN   = 64;
  localparam int REG_AW = 6;
  localparam int W      = 7 + 3 * XLEN + REG_AW;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic              flush = 1'b0;
  logic              mem_read_i = 1'b0, mem_write_i = 1'b0, mem_to_reg_i = 1'b0, reg_write_i = 1'b0;
  logic              jump_i = 1'b0, branch_i = 1'b0, zero_i = 1'b0, reg_dst_i = 1'b0;
  logic [XLEN-1:0]   alu_result_i = '0, rt_data_i = '0, imm_i = '0;
  logic [REG_AW-1:0] rt_i = '0, rd_i = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic              mem_read_o, mem_write_o, mem_to_reg_o, reg_write_o, jump_o, branch_o, zero_o;
  logic [XLEN-1:0]   alu_result_o, rt_data_o, imm_o;
  logic [REG_AW-1:0] wb_reg_o;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] prev_vec;
  logic         prev_stall = 1'b0;

  ex_mem_skid #(.XLEN(XLEN), .REG_AW(REG_AW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
    .mem_read_i(mem_read_i), .mem_write_i(mem_write_i), .mem_to_reg_i(mem_to_reg_i),
    .reg_write_i(reg_write_i), .jump_i(jump_i), .branch_i(branch_i), .zero_i(zero_i),
    .reg_dst_i(reg_dst_i), .alu_result_i(alu_result_i), .rt_data_i(rt_data_i), .imm_i(imm_i),
    .rt_i(rt_i), .rd_i(rd_i), .out_valid(out_valid), .out_ready(out_ready),
    .mem_read_o(mem_read_o), .mem_write_o(mem_write_o), .mem_to_reg_o(mem_to_reg_o),
    .reg_write_o(reg_write_o), .jump_o(jump_o), .branch_o(branch_o), .zero_o(zero_o),
    .alu_result_o(alu_result_o), .rt_data_o(rt_data_o), .imm_o(imm_o), .wb_reg_o(wb_reg_o)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] exp_entry();
    logic [REG_AW-1:0] wb;
    wb = reg_dst_i ? rd_i : rt_i;
    return {mem_read_i, mem_write_i, mem_to_reg_i, reg_write_i, jump_i, branch_i, zero_i,
            alu_result_i, rt_data_i, imm_i, wb};
  endfunction

  function automatic logic [W-1:0] act_entry();
    return {mem_read_o, mem_write_o, mem_to_reg_o, reg_write_o, jump_o, branch_o, zero_o,
            alu_result_o, rt_data_o, imm_o, wb_reg_o};
  endfunction

  task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // ctrl = {mem_read, mem_write, mem_to_reg, reg_write, jump, branch, zero, reg_dst}
  task automatic set_in(input logic v, input logic [XLEN-1:0] alu, input logic [7:0] ctrl,
                        input logic [REG_AW-1:0] rt, input logic [REG_AW-1:0] rd);
    in_valid = v;
    {mem_read_i, mem_write_i, mem_to_reg_i, reg_write_i, jump_i, branch_i, zero_i, reg_dst_i} = ctrl;
    alu_result_i = alu;
    rt_data_i    = alu + 64'h100;
    imm_i        = alu + 64'h200;
    rt_i         = rt;
    rd_i         = rd;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Stimulus side: record every accepted entry, drop the model on flush/reset
  always @(negedge clk) begin
    if (!rst_n || flush) exp_q.delete();
    else if (in_valid && in_ready) exp_q.push_back(exp_entry());
  end

  // Monitor side: compare each popped head, bubble side effects, stall stability
  always @(negedge clk) begin
    if (rst_n && !flush) begin
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected actual=%0h required=none", act_entry());
        end else begin
          if (act_entry() !== exp_q[0]) begin
            errors++;
            $display("FAIL sb_data actual=%0h required=%0h", act_entry(), exp_q[0]);
          end
          void'(exp_q.pop_front());
        end
      end
      if (!out_valid) begin
        checks++;
        if ({mem_read_o, mem_write_o, reg_write_o, jump_o, branch_o} !== 5'b0) begin
          errors++;
          $display("FAIL bubble_side_effects actual=%b required=00000",
                   {mem_read_o, mem_write_o, reg_write_o, jump_o, branch_o});
        end
      end
      if (prev_stall && out_valid) begin
        checks++;
        if (act_entry() !== prev_vec) begin
          errors++;
          $display("FAIL stall_stable actual=%0h required=%0h", act_entry(), prev_vec);
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_vec   = act_entry();
    end else begin
      prev_stall = 1'b0;
    end
  end

  initial begin
    // Reset state
    set_in(1'b0, 64'h0, 8'h00, 6'd0, 6'd0);
    #3;
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("rst_alu", alu_result_o, 64'd0);
    chk("rst_wb", {58'd0, wb_reg_o}, 64'd0);
    #9 rst_n = 1'b1;

    // Streaming 1,2,3
    out_ready = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      step();
      set_in(1'b1, 64'(k), 8'h10, 6'd1, 6'd2);
      @(negedge clk);
      chk("stream_in_ready", {63'd0, in_ready}, 64'd1);
      if (k > 1) begin
        chk("stream_out_valid", {63'd0, out_valid}, 64'd1);
        chk("stream_alu", alu_result_o, 64'(k - 1));
      end
    end
    step();
    set_in(1'b0, 64'h0, 8'h00, 6'd0, 6'd0);
    @(negedge clk);
    chk("stream_alu_last", alu_result_o, 64'd3);
    step();
    @(negedge clk);
    chk("stream_drained", {63'd0, out_valid}, 64'd0);

    // Backpressure A then B
    out_ready = 1'b0;
    step(); set_in(1'b1, 64'hA, 8'h40, 6'd4, 6'd5);
    step(); set_in(1'b1, 64'hB, 8'h20, 6'd6, 6'd8);
    step(); set_in(1'b0, 64'h0, 8'h00, 6'd0, 6'd0);
    @(negedge clk);
    chk("bp_full_in_ready", {63'd0, in_ready}, 64'd0);
    chk("bp_hold_a", alu_result_o, 64'hA);
    step(); out_ready = 1'b1;
    @(negedge clk);
    chk("bp_still_a", alu_result_o, 64'hA);
    step();
    @(negedge clk);
    chk("bp_b", alu_result_o, 64'hB);
    chk("bp_in_ready_back", {63'd0, in_ready}, 64'd1);
    step();
    @(negedge clk);
    chk("bp_empty", {63'd0, out_valid}, 64'd0);

    // Destination select
    step(); set_in(1'b1, 64'h70, 8'h11, 6'd3, 6'd7);
    step(); set_in(1'b1, 64'h71, 8'h10, 6'd3, 6'd7);
    @(negedge clk);
    chk("dest_rd", {58'd0, wb_reg_o}, 64'd7);
    step(); set_in(1'b0, 64'h0, 8'h00, 6'd0, 6'd0);
    @(negedge clk);
    chk("dest_rt", {58'd0, wb_reg_o}, 64'd3);
    step();

    // Flush from FULL with side-effect bits captured
    out_ready = 1'b0;
    step(); set_in(1'b1, 64'h21, 8'h50, 6'd1, 6'd1);
    step(); set_in(1'b1, 64'h22, 8'h50, 6'd2, 6'd2);
    step(); set_in(1'b1, 64'h55, 8'h50, 6'd3, 6'd3); flush = 1'b1;
    @(negedge clk);
    chk("flush_pre_full", {63'd0, in_ready}, 64'd0);
    step(); flush = 1'b0; set_in(1'b0, 64'h0, 8'h00, 6'd0, 6'd0);
    @(negedge clk);
    chk("flush_out_valid", {63'd0, out_valid}, 64'd0);
    chk("flush_reg_write", {63'd0, reg_write_o}, 64'd0);
    chk("flush_mem_write", {63'd0, mem_write_o}, 64'd0);
    chk("flush_in_ready", {63'd0, in_ready}, 64'd1);
    step();
    @(negedge clk);
    chk("flush_discarded", {63'd0, out_valid}, 64'd0);

    // Asynchronous reset while FULL
    step(); set_in(1'b1, 64'h31, 8'h3E, 6'd9, 6'd9);
    step(); set_in(1'b1, 64'h32, 8'h3E, 6'd9, 6'd9);
    step(); set_in(1'b0, 64'h0, 8'h00, 6'd0, 6'd0);
    @(negedge clk);
    chk("ar_pre_alu", alu_result_o, 64'h31);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_out_valid", {63'd0, out_valid}, 64'd0);
    chk("ar_alu", alu_result_o, 64'd0);
    chk("ar_wb", {58'd0, wb_reg_o}, 64'd0);
    chk("ar_ctrl", {57'd0, mem_read_o, mem_write_o, mem_to_reg_o, reg_write_o, jump_o, branch_o, zero_o}, 64'd0);
    chk("ar_in_ready", {63'd0, in_ready}, 64'd1);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("ar_post_empty", {63'd0, out_valid}, 64'd0);
    chk("ar_post_ready", {63'd0, in_ready}, 64'd1);

    // Random valid/ready/flush traffic
    for (int i = 0; i < 2000; i++) begin
      step();
      set_in(1'b1, {$urandom, $urandom}, 8'($urandom), 6'($urandom), 6'($urandom));
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 29) == 0);
    end
    step();
    set_in(1'b0, 64'h0, 8'h00, 6'd0, 6'd0);
    flush = 1'b0;
    out_ready = 1'b1;
    repeat (4) step();
    @(negedge clk);
    chk("drain_empty", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
